risc_ctrl_unit: RTL

//  Multi-cycle sequencer for the 8-bit RISC CPU: fetches 16-bit instructions, drives register-file

---
 rtl/risc_ctrl_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/risc_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : risc_ctrl_unit
//  Purpose  : Multi-cycle sequencer for the 8-bit RISC CPU. Fetches 16-bit
//             instructions, drives the register-file read addresses and the
//             ALU select code, captures the ALU result / zero flag and
//             writes the result back.
//  Ports    : Clk, Rst            - clock, synchronous active-high reset
//             ImemReq/ImemAddr    - instruction fetch request / address (PC)
//             ImemAck/Instr       - fetch acknowledge / instruction word
//             RfAddrA/RfAddrB     - RF read addresses (Rs, Rt) feeding ALU
//             AluSel              - ALU operation select
//             AluOper/AluZero     - ALU result / zero flag
//             RfWe/RfWAddr/RfWData- RF write port (one-cycle pulse in WB)
//             ZFlag               - architectural zero flag
//             Halted/ImemErr      - core stopped / sticky fetch timeout
//             DbgState/DbgIR      - only with RISC_CTRL_DBG_EN defined
//  Config   : `define RISC_CTRL_DBG_EN to expose FSM state and IR.
//  Revision : 1.0 - initial release
// ============================================================================
module risc_ctrl_unit #(
    parameter logic [7:0] RESET_PC      = 8'h00,
    parameter int         FETCH_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        ImemReq,
    output logic [7:0]  ImemAddr,
    input  logic        ImemAck,
    input  logic [15:0] Instr,
    output logic [2:0]  RfAddrA,
    output logic [2:0]  RfAddrB,
    output logic [2:0]  AluSel,
    input  logic [7:0]  AluOper,
    input  logic        AluZero,
    output logic        RfWe,
    output logic [2:0]  RfWAddr,
    output logic [7:0]  RfWData,
    output logic        ZFlag,
    output logic        Halted,
    output logic        ImemErr
`ifdef RISC_CTRL_DBG_EN
    ,
    output logic [2:0]  DbgState,
    output logic [15:0] DbgIR
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_BZ   = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Counter only needs to reach FETCH_TIMEOUT-1; keep at least one bit
    // so the declaration stays legal when the timeout is disabled.
    localparam int                CNT_W        = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [7:0]       pc;
    logic [15:0]      ir;
    logic [7:0]       res;
    logic             zflag;
    logic             imem_err;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             take_branch;

    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm;

    assign op  = ir[15:12];
    assign rd  = ir[11:9];
    assign rs  = ir[8:6];
    assign rt  = ir[5:3];
    assign imm = ir[7:0];

    // Fault only on a non-acked cycle: an ack in the final cycle wins.
    assign timeout_hit = (FETCH_TIMEOUT != 0) && !ImemAck && (wait_cnt == TIMEOUT_LAST);
    assign take_branch = (op == OP_JMP) || ((op == OP_BZ) && zflag);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            res      <= 8'h00;
            zflag    <= 1'b0;
            imem_err <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_FETCH: begin
                    if (ImemAck) begin
                        ir       <= Instr;
                        pc       <= pc + 8'd1;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        imem_err <= 1'b1;
                        wait_cnt <= '0;
                    end else if (FETCH_TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (take_branch) begin
                        pc <= imm;
                    end
                end
                S_EXEC: begin
                    res   <= AluOper;
                    zflag <= AluZero;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (ImemAck) begin
                    state_nxt = S_DECODE;
                end else if (timeout_hit) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                if (!op[3]) begin
                    state_nxt = S_EXEC;
                end else begin
                    case (op)
                        OP_LDI:  state_nxt = S_WB;
                        OP_HALT: state_nxt = S_HALT;
                        default: state_nxt = S_FETCH;
                    endcase
                end
            end
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Request and write enable are masked by Rst so that
    // no fetch starts and no RF write lands while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        ImemReq  = 1'b0;
        RfAddrA  = 3'd0;
        RfAddrB  = 3'd0;
        AluSel   = 3'd0;
        RfWe     = 1'b0;
        RfWAddr  = 3'd0;
        RfWData  = 8'h00;
        ImemAddr = pc;
        ZFlag    = zflag;
        ImemErr  = imem_err;
        Halted   = (state == S_HALT);
        case (state)
            S_FETCH: ImemReq = !Rst;
            S_DECODE: begin
                RfAddrA = rs;
                RfAddrB = rt;
            end
            S_EXEC: begin
                RfAddrA = rs;
                RfAddrB = rt;
                AluSel  = op[2:0];
            end
            S_WB: begin
                RfWe    = !Rst;
                RfWAddr = rd;
                RfWData = (op == OP_LDI) ? imm : res;
            end
            default: ;
        endcase
    end

`ifdef RISC_CTRL_DBG_EN
    assign DbgState = state;
    assign DbgIR    = ir;
`else
    // Debug outputs not present in this build.
`endif

endmodule
`default_nettype wire
